// File: rtl/goertzel_hit_detect_if.sv
`default_nettype none
// ============================================================================
// Interface   : goertzel_hit_detect_if
// Description : Event-queue side of the goertzel hit detector. The detector
//               (master) presents the show-ahead FIFO head and status flags.
//               The software/Avalon side (slave) pops entries and clears the
//               sticky overflow flag.
//   evt_data   master->slave  FIFO head {frame_cnt[15:0], hit_vec}, 0 when empty
//   evt_empty  master->slave  FIFO empty
//   overflow   master->slave  sticky, an event was dropped on a full FIFO
//   evt_rd     slave->master  pop head (ignored when empty)
//   ovf_clr    slave->master  clear overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface goertzel_hit_detect_if #(
    parameter int EVT_W = 20
);
    logic [EVT_W-1:0] evt_data;
    logic             evt_empty;
    logic             overflow;
    logic             evt_rd;
    logic             ovf_clr;

    modport master (
        output evt_data,
        output evt_empty,
        output overflow,
        input  evt_rd,
        input  ovf_clr
    );

    modport slave (
        input  evt_data,
        input  evt_empty,
        input  overflow,
        output evt_rd,
        output ovf_clr
    );
endinterface
`default_nettype wire

// File: rtl/goertzel_hit_detect.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_hit_detect
// Description : Collects one power result per goertzel bin per frame,
//               compares each against a signed threshold, mutes a bin for
//               HOLDOFF_FRAMES frames after it fires, and queues hit events
//               in a show-ahead FIFO.
//   clk        system clock
//   reset      asynchronous active-low reset
//   advance    per-bin frame-done level (rising edge = result ready)
//   power_in   signed powers, bin i at [i*POWER_W +: POWER_W]
//   threshold  signed hit threshold (quasi-static)
//   hit_valid  one-cycle pulse for a frame with at least one hit
//   hit_vec    bins that hit on the last pulse (held)
//   sync_err   sticky, a bin completed twice within one frame
//   evt        event FIFO port (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module goertzel_hit_detect #(
    parameter int NUM_BINS       = 4,
    parameter int POWER_W        = 64,
    parameter int HOLDOFF_FRAMES = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_BINS-1:0]         advance,
    input  logic [NUM_BINS*POWER_W-1:0] power_in,
    input  logic signed [POWER_W-1:0]   threshold,
    output logic                        hit_valid,
    output logic [NUM_BINS-1:0]         hit_vec,
    output logic                        sync_err,
    goertzel_hit_detect_if.master       evt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EVT_W = 16 + NUM_BINS;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       HOLD_INIT = 8'(HOLDOFF_FRAMES);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       snap;
    logic       cmp_en;
    logic       emit_en;

    logic [NUM_BINS-1:0]       adv_q;
    logic [NUM_BINS-1:0]       adv_edge;
    logic [NUM_BINS-1:0]       pending;
    logic [NUM_BINS-1:0]       above;
    logic [NUM_BINS-1:0]       hold_zero;
    logic [NUM_BINS-1:0]       hit_now;
    logic [NUM_BINS-1:0]       hit_q;
    logic signed [POWER_W-1:0] cap [NUM_BINS];
    logic signed [POWER_W-1:0] cmp [NUM_BINS];
    logic [7:0]                hold [NUM_BINS];
    logic [15:0]               frame_cnt;

    // FIFO
    logic [EVT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [EVT_W-1:0] push_data;
    logic [EVT_W-1:0] head_nxt;
    logic [EVT_W-1:0] evt_data_q;
    logic             evt_empty_q;
    logic             overflow_q;
    logic             push;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign adv_edge = advance & ~adv_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (&pending) state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_EMIT;
            ST_EMIT:    state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        snap    = 1'b0;
        cmp_en  = 1'b0;
        emit_en = 1'b0;
        case (state)
            ST_COLLECT: snap    = &pending;
            ST_COMPARE: cmp_en  = 1'b1;
            ST_EMIT:    emit_en = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture: runs every cycle regardless of FSM state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adv_q    <= '0;
            pending  <= '0;
            sync_err <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                cap[i] <= '0;
                cmp[i] <= '0;
            end
        end else begin
            adv_q <= advance;
            // On the snap cycle the cleared mask picks up any new edge, so
            // that edge belongs to the next frame and is not a repeat.
            pending <= snap ? adv_edge : (pending | adv_edge);
            if (|(adv_edge & pending & ~{NUM_BINS{snap}})) begin
                sync_err <= 1'b1;
            end
            for (int i = 0; i < NUM_BINS; i++) begin
                if (adv_edge[i]) cap[i] <= power_in[i*POWER_W +: POWER_W];
                if (snap)        cmp[i] <= cap[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare and hold-off
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        assign above[g]     = (cmp[g] > threshold);
        assign hold_zero[g] = (hold[g] == 8'd0);
        assign hit_now[g]   = above[g] & hold_zero[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q     <= '0;
            hit_valid <= 1'b0;
            hit_vec   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < NUM_BINS; i++) hold[i] <= '0;
        end else begin
            // The pulse is raised at the end of COMPARE so it is visible
            // during the EMIT cycle, together with the FIFO push request.
            hit_valid <= cmp_en & (|hit_now);
            if (cmp_en) begin
                hit_q <= hit_now;
                if (|hit_now) hit_vec <= hit_now;
            end
            if (emit_en) begin
                frame_cnt <= frame_cnt + 16'd1;
                for (int i = 0; i < NUM_BINS; i++) begin
                    if (hit_q[i])              hold[i] <= HOLD_INIT;
                    else if (hold[i] != 8'd0)  hold[i] <= hold[i] - 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO with a registered head copy
    // ------------------------------------------------------------------
    assign push      = emit_en & (|hit_q);
    assign push_data = {frame_cnt, hit_q};
    assign do_pop    = evt.evt_rd & (count != '0);
    assign do_push   = push & ((count != FULL_CNT) | do_pop);
    assign drop      = push & (count == FULL_CNT) & ~do_pop;
    assign rd_nxt    = rd_ptr + PTR_W'(do_pop);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + CNT_W'(1);
        else if (do_pop && !do_push) count_nxt = count - CNT_W'(1);
    end

    // A push that becomes the only entry is not yet in memory, so it is
    // forwarded straight into the head register.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (count_nxt == '0)                       head_nxt = '0;
        else if (do_push && count_nxt == CNT_W'(1)) head_nxt = push_data;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            evt_data_q  <= '0;
            evt_empty_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr      <= rd_nxt;
            count       <= count_nxt;
            evt_data_q  <= head_nxt;
            evt_empty_q <= (count_nxt == '0);
            if (evt.ovf_clr)  overflow_q <= 1'b0;
            else if (drop)    overflow_q <= 1'b1;
        end
    end

    assign evt.evt_data  = evt_data_q;
    assign evt.evt_empty = evt_empty_q;
    assign evt.overflow  = overflow_q;

endmodule
`default_nettype wire
